input_conditioner: RTL and testbench

- Upstream stage of the game FSM. Turns the 8 raw, asynchronous, bouncy push-button lines (two players × Left/Right/Drop/Start) into clean signals.
- Outputs are single-cycle, Clk-synchronous pulses that drive the game FSM's Left1..Start2 inputs directly.
- Per button: 2-FF synchronizer, debounce FSM, rising-edge one-shot.
- Also exports the debounced levels for LEDs and the display.

---
 rtl/input_conditioner.sv | 112 +++++++++++
 tb/tb_input_conditioner.sv | 120 ++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and one-shots 8 raw push-buttons into game FSM press pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses on the Left/Right buttons.
module input_conditioner #(
    parameter int DB_COUNT      = 500000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_DELAY  = 40000000,
    parameter int REPEAT_PERIOD = 15000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] btn_raw,
    output logic       Left1,
    output logic       Right1,
    output logic       Drop1,
    output logic       Start1,
    output logic       Left2,
    output logic       Right2,
    output logic       Drop2,
    output logic       Start2,
    output logic [7:0] btn_level
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);
    if (DB_COUNT < 2 || DB_COUNT > 2**CNT_W - 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("input_conditioner: illegal parameter values");
    end
    logic [7:0] meta_q, sync_q, pulse_q, level_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end
    for (genvar i = 0; i < 8; i++) begin : g_btn
        state_t state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic pulse_q_i, pulse_d, level_q_i, level_d, rep_fire;
        wire s = sync_q[i];
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                pulse_q_i <= 1'b0;
                level_q_i <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pulse_q_i <= pulse_d;
                level_q_i <= level_d;
            end
        end
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
                PRESS_WAIT: if (!s || cnt_q == LAST) begin
                    state_d = s ? HELD : IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
                HELD: if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
                default: if (s || cnt_q == LAST) begin
                    state_d = s ? HELD : IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
            endcase
        end
        // A pulse marks HELD while the level is still low, so bounce re-entry from RELEASE_WAIT stays silent.
        always_comb begin
            level_d = state_q == HELD || state_q == RELEASE_WAIT;
            pulse_d = (state_q == HELD && !level_q_i) || rep_fire;
        end
`ifdef AUTO_REPEAT_EN
        if (i % 4 < 2) begin : g_rep
            localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
            logic [RPT_W-1:0] rcnt_q, rcnt_d;
            logic rep_q, rep_d;
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    rcnt_q <= '0;
                    rep_q  <= 1'b0;
                end else begin
                    rcnt_q <= rcnt_d;
                    rep_q  <= rep_d;
                end
            end
            always_comb begin
                rep_fire = state_q == HELD && rcnt_q == (rep_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY));
                rcnt_d   = state_q != HELD ? '0 : rep_fire ? RPT_W'(1) : rcnt_q + RPT_W'(1);
                rep_d    = state_q == HELD && (rep_q || rep_fire);
            end
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end
`else
        assign rep_fire = 1'b0;
`endif
        assign pulse_q[i] = pulse_q_i;
        assign level_q[i] = level_q_i;
    end
    assign {Start2, Drop2, Right2, Left2, Start1, Drop1, Right1, Left1} = pulse_q;
    assign btn_level = level_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce latency, bounce rejection, simultaneity and reset.
module tb_input_conditioner;
    logic Clk = 1'b0, Reset = 1'b1;
    logic [7:0] btn_raw = '0;
    logic Left1, Right1, Drop1, Start1, Left2, Right2, Drop2, Start2;
    logic [7:0] btn_level, pv;
    int n_cmp = 0, n_bad = 0, np;
    always #5 Clk = ~Clk;
    input_conditioner #(.DB_COUNT(4), .CNT_W(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw),
        .Left1(Left1), .Right1(Right1), .Drop1(Drop1), .Start1(Start1),
        .Left2(Left2), .Right2(Right2), .Drop2(Drop2), .Start2(Start2),
        .btn_level(btn_level)
    );
    assign pv = {Start2, Drop2, Right2, Left2, Start1, Drop1, Right1, Left1};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask
    // Advance n edges, counting every pulse seen on any output.
    task automatic run(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            cnt += $countones(pv);
        end
    endtask
    initial begin
        repeat (2) tick();
        check("reset_pulses", pv, 0);
        check("reset_level", btn_level, 0);
        Reset = 1'b0;
        repeat (3) tick();
        // clean press on Left1: pulse lands 7 edges after the raw change
        btn_raw[0] = 1'b1;
        run(6, np);
        check("press_early", np, 0);
        check("press_level_early", btn_level, 8'h00);
        tick();
        check("press_pulse", pv, 8'h01);
        check("press_level", btn_level, 8'h01);
        run(50, np);
        check("hold_no_repeat", np, 0);
        check("hold_level", btn_level, 8'h01);
        btn_raw[0] = 1'b0;
        run(6, np);
        check("release_level_early", btn_level, 8'h01);
        tick();
        check("release_level", btn_level, 8'h00);
        check("release_no_pulse", np, 0);
        repeat (4) tick();
        // bouncy press on Drop1
        np = 0;
        for (int k = 0; k < 4; k++) begin
            btn_raw[2] = ~k[0];
            tick();
            np += $countones(pv);
        end
        btn_raw[2] = 1'b1;
        begin
            int m;
            run(6, m);
            check("bounce_no_pulse", np + m, 0);
        end
        tick();
        check("bounce_pulse", pv, 8'h04);
        check("bounce_level", btn_level, 8'h04);
        // short release glitch while held
        btn_raw[2] = 1'b0;
        repeat (2) tick();
        btn_raw[2] = 1'b1;
        run(12, np);
        check("rel_bounce_no_pulse", np, 0);
        check("rel_bounce_level", btn_level, 8'h04);
        btn_raw[2] = 1'b0;
        run(6, np);
        check("full_release_early", btn_level, 8'h04);
        tick();
        check("full_release", btn_level, 8'h00);
        repeat (4) tick();
        // simultaneous Left1, Right1, Start2
        btn_raw = 8'h83;
        run(6, np);
        check("simul_early", np, 0);
        tick();
        check("simul_pulse", pv, 8'h83);
        tick();
        check("simul_one_cycle", pv, 8'h00);
        check("simul_level", btn_level, 8'h83);
        btn_raw = 8'h00;
        repeat (10) tick();
        check("simul_released", btn_level, 8'h00);
        // reset mid-debounce on Start1, button kept held
        btn_raw[3] = 1'b1;
        repeat (4) tick();
        Reset = 1'b1;
        #1;
        check("rst_mid_pulses", pv, 0);
        check("rst_mid_level", btn_level, 0);
        repeat (2) tick();
        check("rst_hold_pulses", pv, 0);
        Reset = 1'b0;
        run(6, np);
        check("rst_restart_early", np, 0);
        tick();
        check("rst_restart_pulse", pv, 8'h08);
        check("rst_restart_level", btn_level, 8'h08);
        run(20, np);
        check("rst_restart_single", np, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
